// File: rtl/pu_i2c_slave_driver_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package : i2c_slave_pkg
// Brief   : shared state encoding and line-level constants for the I2C target
// Revision: 1.0
// ============================================================================
package i2c_slave_pkg;

    localparam int   I2C_BYTE   = 8;
    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pu_i2c_slave_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface : pu_i2c_slave_driver_if
// Brief     : one-byte handshake between the I2C target and slave-side splitters
// Revision  : 1.0
// ============================================================================
interface pu_i2c_slave_driver_if #(
    parameter int WIDTH = i2c_slave_pkg::I2C_BYTE
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             ready_write;
    logic             i2c_prepare;
    logic             busy;
    logic             flag_stop;

    // master: the I2C driver that owns the handshake; slave: the splitter side
    modport master (
        input  data_in,
        output data_out, ready_write, i2c_prepare, busy, flag_stop
    );
    modport slave (
        output data_in,
        input  data_out, ready_write, i2c_prepare, busy, flag_stop
    );
endinterface
`default_nettype wire

// File: rtl/pu_i2c_slave_driver_line_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : i2c_line_sync
// Brief   : 2-FF synchroniser for one I2C line with rise/fall pulse outputs
// Revision: 1.0
// ============================================================================
module i2c_line_sync (
    input  wire  clk,
    input  wire  rst,
    input  wire  line,
    output logic level,
    output logic rise,
    output logic fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the idle-bus level so coming out of reset never fakes a START
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;
endmodule
`default_nettype wire

// File: rtl/pu_i2c_slave_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pu_i2c_slave_driver
// Brief   : byte-level I2C target: address match, ACK, byte RX/TX handshake
// Revision: 1.0
// ============================================================================
module pu_i2c_slave_driver
    import i2c_slave_pkg::*;
#(
    parameter int         I2C_DATA_WIDTH = 8,
    parameter logic [6:0] ADDRES_DEVICE  = 7'h47
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    scl,
    inout  wire                    sda,
    pu_i2c_slave_driver_if.master  bus
);
    localparam int         c_msb  = I2C_DATA_WIDTH - 1;
    localparam logic [3:0] c_last = 4'(I2C_DATA_WIDTH - 1);
    localparam logic [3:0] c_bits = 4'(I2C_DATA_WIDTH);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    i2c_line_sync u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (scl),
        .level (w_scl_lvl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (sda),
        .level (w_sda_lvl),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    state_t                  r_state, w_state_next;
    logic [3:0]              r_cnt, w_cnt_next;
    logic [c_msb:0]          r_shift, w_shift_next;
    logic [c_msb:0]          r_data_out, w_data_out_next;
    logic                    r_sda_low, w_sda_low_next;
    logic                    r_rw, w_rw_next;
    logic                    r_busy, w_busy_next;
    logic                    r_ready_write, w_ready_write_next;
    logic                    r_prepare, w_prepare_next;
    logic                    r_flag_stop, w_flag_stop_next;

    logic [c_msb:0] w_shift_in;
    logic           w_start;
    logic           w_stop;

    assign w_shift_in = {r_shift[c_msb-1:0], w_sda_lvl};
    // Bus conditions are ignored while we hold sda, so our own ACK/data never looks like one
    assign w_start    = w_sda_fall & w_scl_lvl & ~r_sda_low;
    assign w_stop     = w_sda_rise & w_scl_lvl & ~r_sda_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_sda_low     <= 1'b0;
            r_rw          <= 1'b0;
            r_busy        <= 1'b0;
            r_ready_write <= 1'b0;
            r_prepare     <= 1'b0;
            r_flag_stop   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_shift       <= w_shift_next;
            r_data_out    <= w_data_out_next;
            r_sda_low     <= w_sda_low_next;
            r_rw          <= w_rw_next;
            r_busy        <= w_busy_next;
            r_ready_write <= w_ready_write_next;
            r_prepare     <= w_prepare_next;
            r_flag_stop   <= w_flag_stop_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_shift_next       = r_shift;
        w_data_out_next    = r_data_out;
        w_sda_low_next     = r_sda_low;
        w_rw_next          = r_rw;
        w_busy_next        = r_busy;
        w_ready_write_next = 1'b0;
        w_prepare_next     = 1'b0;
        w_flag_stop_next   = 1'b0;

        // The supplier answers i2c_prepare one cycle later with the next TX byte
        if (r_prepare) begin
            w_shift_next = bus.data_in;
        end

        if (w_stop) begin
            w_state_next     = ST_IDLE;
            w_cnt_next       = '0;
            w_sda_low_next   = 1'b0;
            w_busy_next      = 1'b0;
            w_flag_stop_next = 1'b1;
        end else if (w_start) begin
            w_state_next   = ST_ADDR;
            w_cnt_next     = '0;
            w_sda_low_next = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_shift_in;
                        w_cnt_next   = r_cnt + 4'd1;
                        if (r_cnt == c_last) begin
                            w_cnt_next = '0;
                            if (w_shift_in[c_msb:1] == ADDRES_DEVICE) begin
                                w_state_next   = ST_ADDR_ACK;
                                w_busy_next    = 1'b1;
                                w_rw_next      = w_shift_in[0];
                                w_prepare_next = w_shift_in[0];
                            end else begin
                                w_state_next = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                // cnt==0: waiting for the fall after bit 8; cnt==1: 9th clock seen
                ST_ADDR_ACK, ST_RX_ACK: begin
                    if (w_scl_rise) begin
                        w_cnt_next = 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_sda_low_next = 1'b1;
                        end else begin
                            w_cnt_next = '0;
                            if (r_state == ST_ADDR_ACK && r_rw) begin
                                w_state_next   = ST_TX;
                                w_sda_low_next = (r_shift[c_msb] == ACK_LEVEL);
                            end else begin
                                w_state_next   = ST_RX;
                                w_sda_low_next = 1'b0;
                            end
                        end
                    end
                end
                ST_RX: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_shift_in;
                        w_cnt_next   = r_cnt + 4'd1;
                        if (r_cnt == c_last) begin
                            w_cnt_next         = '0;
                            w_data_out_next    = w_shift_in;
                            w_ready_write_next = 1'b1;
                            w_state_next       = ST_RX_ACK;
                        end
                    end
                end
                // cnt==0 on a fall means the MSB has not been placed on the line yet
                ST_TX: begin
                    if (w_scl_rise) begin
                        w_cnt_next = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_sda_low_next = (r_shift[c_msb] == ACK_LEVEL);
                        end else if (r_cnt == c_bits) begin
                            w_cnt_next     = '0;
                            w_sda_low_next = 1'b0;
                            w_state_next   = ST_TX_ACK;
                        end else begin
                            w_shift_next   = {r_shift[c_msb-1:0], 1'b0};
                            w_sda_low_next = (r_shift[c_msb-1] == ACK_LEVEL);
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (w_scl_rise) begin
                        w_cnt_next = '0;
                        if (w_sda_lvl == NACK_LEVEL) begin
                            w_state_next = ST_WAIT_STOP;
                        end else begin
                            w_prepare_next = 1'b1;
                            w_state_next   = ST_TX;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda             = r_sda_low ? ACK_LEVEL : 1'bz;
    assign bus.data_out    = r_data_out;
    assign bus.ready_write = r_ready_write;
    assign bus.i2c_prepare = r_prepare;
    assign bus.busy        = r_busy;
    assign bus.flag_stop   = r_flag_stop;
endmodule
`default_nettype wire

// File: tb/tb_pu_i2c_slave_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_pu_i2c_slave_driver
// Brief   : bit-banged I2C master with event scoreboard for pu_i2c_slave_driver
// Revision: 1.0
// ============================================================================
module tb_pu_i2c_slave_driver;

    localparam int EV_RW   = 1;
    localparam int EV_PREP = 2;
    localparam int EV_STOP = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic scl_m     = 1'b1;
    logic sda_m_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = sda_m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    pu_i2c_slave_driver_if bus ();

    pu_i2c_slave_driver #(
        .I2C_DATA_WIDTH (8),
        .ADDRES_DEVICE  (7'h47)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl_m),
        .sda (sda),
        .bus (bus.master)
    );

    ev_t        exp_q[$];
    chk_t       chk_q[$];
    logic [7:0] tx_q[$];
    int         n_compared = 0;
    int         n_failed   = 0;
    int         pull_count = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
        chk_q.push_back('{n, a, x});
    endfunction

    function automatic void expect_ev(int k, logic [7:0] d);
        exp_q.push_back('{k, d});
    endfunction

    // Monitor: sole owner of the counters; compares DUT pulses and queued checks
    always @(negedge clk) begin
        chk_t c;
        ev_t  e;
        int   kind;
        int   npulse;
        if (rst) begin
            bus.data_in = 8'h00;
        end else begin
            if (sda === 1'b0 && !sda_m_low) pull_count++;
            npulse = int'(bus.ready_write) + int'(bus.i2c_prepare) + int'(bus.flag_stop);
            if (npulse != 0) begin
                kind = bus.ready_write ? EV_RW : (bus.i2c_prepare ? EV_PREP : EV_STOP);
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_failed++;
                    $display("FAIL unexpected_event: got kind=%0d data=%02h pulses=%0d, required none",
                             kind, bus.data_out, npulse);
                end else begin
                    e = exp_q.pop_front();
                    if (npulse != 1 || kind != e.kind || (kind == EV_RW && bus.data_out != e.data)) begin
                        n_failed++;
                        $display("FAIL event: got kind=%0d data=%02h pulses=%0d, required kind=%0d data=%02h pulses=1",
                                 kind, bus.data_out, npulse, e.kind, e.data);
                    end
                end
                if (bus.i2c_prepare) bus.data_in = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
            end
        end
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            n_compared++;
            if (c.act !== c.exp) begin
                n_failed++;
                $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
            end
        end
    end

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        half(); sda_m_low = ~b;
        half(); scl_m = 1'b1;
        half(); s = sda;
        half(); scl_m = 1'b0;
    endtask

    task automatic start_cond();
        half(); sda_m_low = 1'b0;
        half(); scl_m = 1'b1;
        half(); sda_m_low = 1'b1;
        half(); scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        half(); sda_m_low = 1'b1;
        half(); scl_m = 1'b1;
        half(); sda_m_low = 1'b0;
        half();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(~master_ack, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic       s;
        int         pulls;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data_out", 32'(bus.data_out), 32'h0);
        chk("reset_pulses", {29'd0, bus.ready_write, bus.i2c_prepare, bus.flag_stop}, 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_sda", 32'(sda), 32'h1);

        // Write to own address
        expect_ev(EV_RW, 8'h12);
        expect_ev(EV_RW, 8'h34);
        start_cond();
        write_byte(8'h8E, ack); chk("wr_addr_ack", 32'(ack), 32'h0);
        chk("wr_busy", 32'(bus.busy), 32'h1);
        write_byte(8'h12, ack); chk("wr_d0_ack", 32'(ack), 32'h0);
        write_byte(8'h34, ack); chk("wr_d1_ack", 32'(ack), 32'h0);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        chk("wr_busy_after_stop", 32'(bus.busy), 32'h0);

        // Wrong address
        pulls = pull_count;
        start_cond();
        write_byte(8'h90, ack); chk("bad_addr_nack", 32'(ack), 32'h1);
        write_byte(8'hAA, ack); chk("bad_data_nack", 32'(ack), 32'h1);
        chk("bad_busy", 32'(bus.busy), 32'h0);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        chk("bad_never_driven", 32'(pull_count - pulls), 32'h0);

        // Read two bytes, ACK then NACK
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        expect_ev(EV_PREP, 8'h00);
        start_cond();
        write_byte(8'h8F, ack); chk("rd_addr_ack", 32'(ack), 32'h0);
        expect_ev(EV_PREP, 8'h00);
        read_byte(1'b1, rd); chk("rd_byte0", 32'(rd), 32'hA5);
        read_byte(1'b0, rd); chk("rd_byte1", 32'(rd), 32'h3C);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        chk("rd_busy_after_stop", 32'(bus.busy), 32'h0);

        // Repeated START: write then read
        tx_q.push_back(8'hC3);
        expect_ev(EV_RW, 8'h55);
        start_cond();
        write_byte(8'h8E, ack); chk("rs_wr_ack", 32'(ack), 32'h0);
        write_byte(8'h55, ack); chk("rs_d_ack", 32'(ack), 32'h0);
        expect_ev(EV_PREP, 8'h00);
        start_cond();
        chk("rs_busy_after_rstart", 32'(bus.busy), 32'h1);
        write_byte(8'h8F, ack); chk("rs_rd_ack", 32'(ack), 32'h0);
        read_byte(1'b0, rd); chk("rs_rd_byte", 32'(rd), 32'hC3);
        chk("rs_busy_before_stop", 32'(bus.busy), 32'h1);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();

        // STOP mid-byte
        start_cond();
        write_byte(8'h8E, ack); chk("mid_addr_ack", 32'(ack), 32'h0);
        bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b1, s);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        chk("mid_busy", 32'(bus.busy), 32'h0);
        chk("mid_sda_released", 32'(sda), 32'h1);

        // Reset while the ACK is being driven
        start_cond();
        for (int i = 7; i >= 0; i--) bit_xfer(1'(8'h8E >> i), s);
        half(); sda_m_low = 1'b0;
        half();
        chk("rst_ack_driven", 32'(sda), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sda_released", 32'(sda), 32'h1);
        chk("rst_data_out", 32'(bus.data_out), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        half();
        expect_ev(EV_RW, 8'h77);
        start_cond();
        write_byte(8'h8E, ack); chk("post_rst_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h77, ack); chk("post_rst_d_ack", 32'(ack), 32'h0);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        chk("post_rst_busy", 32'(bus.busy), 32'h0);

        repeat (20) @(negedge clk);
        chk("events_outstanding", 32'(exp_q.size()), 32'h0);
        chk("tx_bytes_outstanding", 32'(tx_q.size()), 32'h0);
        for (int i = 0; i < 50 && chk_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pu_i2c_slave_driver.md
# pu_i2c_slave_driver

Byte-level I2C slave (target) driver: the far end of the master-side I2C processing unit. It recognises START, repeated START and STOP, matches its 7-bit address and ACKs. It shifts bytes in (master write) or out (master read) and exposes a one-byte handshake toward the slave-side splitters/buffers. It sits between the filtered SCL/SDA pins and the `i2c_to_nitta`/`nitta_to_i2c` splitters of a slave PU.

## Interface
Parameters:
- `I2C_DATA_WIDTH`, default 8: byte width; only 8 is supported.
- `ADDRES_DEVICE`, default 7'h47: own 7-bit slave address.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `scl`  in  1  I2C clock, bounce-filtered externally; asynchronous to `clk`.
- `sda`  inout  1  I2C data, open-drain: the block drives only `1'b0` or `1'bz`.
- `data_in`  in  8  next byte to transmit; sampled the cycle after `i2c_prepare`.
- `data_out`  out  8  last received byte.
- `ready_write`  out  1  one-cycle pulse: `data_out` holds a new byte.
- `i2c_prepare`  out  1  one-cycle pulse: supply the next TX byte on `data_in`.
- `busy`  out  1  high from an address match until STOP.
- `flag_stop`  out  1  one-cycle pulse on a STOP condition, in any state.

## Operation
- **Line sampling:** `scl` and `sda` input are each passed through a 2-FF synchroniser. Edges are detected on the synchronised values.
- **START:** sda falls while scl is high. **STOP:** sda rises while scl is high. Both are evaluated only while the block is not driving sda.
- **Bit timing:** data bits are sampled on the scl rising edge. The block changes its sda drive only on a scl falling edge.
- **FSM states:** IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
  - IDLE: START -> ADDR. Bit counter cleared.
  - ADDR: shift in 8 bits (7 address bits plus R/W). After the 8th rising edge: on address match -> ADDR_ACK with `busy`=1; on mismatch -> WAIT_STOP with sda never driven.
  - ADDR_ACK: drive sda low from the falling edge after bit 8 until the falling edge after bit 9. Then go to RX if R/W=0, or to TX if R/W=1.
  - RX: after the 8th rising edge, update `data_out` and pulse `ready_write` on the same cycle. Then -> RX_ACK, which drives the ACK the same way as ADDR_ACK and returns to RX.
  - TX: the first byte's `i2c_prepare` pulse occurs on the cycle the address byte's 8th rising edge is seen. `data_in` is loaded into the shift register on the next cycle. The MSB is driven on the falling edge that ends the ACK. A 1 bit releases sda; a 0 bit pulls it low. After 8 bits, release sda -> TX_ACK.
  - TX_ACK: sample the master ACK on the 9th rising edge.
    - ACK (sda=0): pulse `i2c_prepare` on that cycle and return to TX.
    - NACK (sda=1): go to WAIT_STOP.
  - WAIT_STOP: sda released; ignore bits until STOP or repeated START.
- **Repeated START** in any state: go to ADDR, release sda, clear the bit counter. `busy` stays high.
- **STOP** in any state: go to IDLE, release sda, clear `busy`, pulse `flag_stop`. A partially received byte is discarded and no `ready_write` is issued.

## Timing
- **Reset values:** `data_out`=0, `ready_write`=0, `i2c_prepare`=0, `busy`=0, `flag_stop`=0, sda released, state IDLE.
- **Synchroniser latency:** 2 clk, plus 1 clk for edge detection.
- **Minimum SCL high and low time:** 4 clk each. Behaviour is undefined below this.
- **Pulses:** `ready_write`, `i2c_prepare` and `flag_stop` are exactly one cycle wide and never overlap.
- **`data_out`** is stable until the next `ready_write`.
- **SDA drive** changes no later than 1 clk after the detected scl fall. It is always released before any STOP or START can be generated by the master.
- **Reset mid-transaction:** sda is released on the next clk edge. The block stays IDLE until a fresh START.

## Structure
- **Package `i2c_slave_pkg`:** state enum (8 states, 3-bit encoding), `I2C_BYTE=8`, ACK/NACK level constants.
- **Sub-module `i2c_line_sync`:** a 2-FF synchroniser plus rise/fall pulse detector. Instantiate one each for scl and sda.
- **Top-level logic:** FSM, 4-bit bit counter, 8-bit shift register, sda drive register.

## Test plan
- **Write to own address:** START, 0x8E (0x47<<1|0), 0x12, 0x34, STOP -> three ACKs on sda. `ready_write` pulses twice, with `data_out`=0x12 then 0x34. One `flag_stop` pulse.
- **Wrong address:** START, 0x90, 0xAA, STOP -> sda never driven low, no `ready_write`, `busy` stays 0, `flag_stop` pulses.
- **Read:** START, 0x8F. The bench answers each `i2c_prepare` with 0xA5 then 0x3C. Master ACKs the first byte and NACKs the second -> sda carries 0xA5 then 0x3C. `i2c_prepare` pulses twice, then WAIT_STOP until STOP.
- **Repeated START:** write 0x8E, 0x55, then repeated START, 0x8F, read one byte -> `ready_write` with 0x55, then TX of `data_in`. `busy` stays high throughout.
- **STOP mid-byte:** write 0x8E, then 4 bits, then STOP -> no `ready_write`, state IDLE, sda released.
- **Reset during ACK:** assert `rst` while the block drives ACK -> sda released on the next clk and all outputs at their reset values. A new write of 0x8E, 0x77 then completes normally.
